fetch_sequencer: RTL

Instruction-fetch controller that owns the program counter and sequences instruction-memory requests for the front end. Issues PC-addressed requests over a valid/ready channel, pairs in-order responses with their PC, buffers up to two fetched instructions for decode, and handles redirects (branch/jump) by flushing buffered and in-flight instructions. Sits between the instruction memory and decode, and provides the `pc_o`/`insn_o` pair to decode.

---
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the front end.
//
// Owns the fetch PC, issues PC-addressed requests to instruction memory,
// pairs in-order responses with the PC that produced them, and keeps up
// to two fetched {pc, insn} entries for decode. A redirect flushes the
// queue and marks every in-flight request to be dropped on return. A halt
// stops request issue for good (until rst), but responses already in
// flight still retire and the queue keeps draining.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   redirect_i/_pc_i       redirect fetch to a new PC (used verbatim)
//   halt_i                 stop issuing requests; latched until rst
//   imem_req_valid_o/_ready_i/_addr_o   request channel to memory
//   imem_rsp_valid_i/_data_i            in-order response channel
//   insn_valid_o/_ready_i, pc_o, insn_o decode-side head of the queue
//   halted_o               high while the FSM is in HALTED
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The request side holds valid and
// addr stable until accepted, except that redirect_i, halt_i or rst may
// withdraw an unaccepted request. Responses carry no ready: memory returns
// them in order, at least one cycle after acceptance.

module fetch_sequencer #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e            state_q;
    logic              halted_q;

    logic [AWIDTH-1:0] fpc_q, fpc_d;
    logic [1:0]        out_cnt_q, out_cnt_d;
    logic [1:0]        drop_cnt_q, drop_cnt_d;
    logic [1:0]        occ_q, occ_d;

    // In-flight PC FIFO: one entry per accepted, not yet answered request.
    logic [AWIDTH-1:0] ifl_pc_q [2];
    logic              ifl_wr_q, ifl_rd_q;

    // Decode-side instruction queue.
    logic [AWIDTH-1:0] q_pc_q   [2];
    logic [DWIDTH-1:0] q_insn_q [2];
    logic              q_wr_q, q_rd_q;

    logic              in_run;
    logic              pop;
    logic              redirect_take;
    logic [2:0]        credit_used;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_drop;
    logic              enq;
    logic [AWIDTH-1:0] rsp_pc;

    assign in_run        = (state_q == ST_RUN);
    assign insn_valid_o  = (occ_q != 2'd0);
    assign pop           = insn_valid_o && insn_ready_i;
    // halt_i beats a simultaneous redirect: the redirect is simply ignored.
    assign redirect_take = in_run && redirect_i && !halt_i;

    // Two credits shared by in-flight requests and queued instructions, so
    // every response always has a queue slot. A same-cycle pop frees a
    // credit early, which is what sustains one instruction per cycle.
    assign credit_used   = {1'b0, out_cnt_q} + {1'b0, occ_q} - {2'b00, pop};

    assign imem_req_valid_o = in_run && !halt_i && !redirect_i && (credit_used < 3'd2);
    assign imem_req_addr_o  = fpc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_take = imem_rsp_valid_i && (out_cnt_q != 2'd0);
    // Responses to pre-redirect requests are discarded, including one that
    // lands in the redirect cycle itself.
    assign rsp_drop = rsp_take && ((drop_cnt_q != 2'd0) || redirect_take);
    assign enq      = rsp_take && !rsp_drop;
    assign rsp_pc   = ifl_pc_q[ifl_rd_q];

    assign pc_o     = insn_valid_o ? q_pc_q[q_rd_q]   : '0;
    assign insn_o   = insn_valid_o ? q_insn_q[q_rd_q] : '0;
    assign halted_o = halted_q;

    always_comb begin
        fpc_d      = fpc_q;
        out_cnt_d  = out_cnt_q + {1'b0, req_fire} - {1'b0, rsp_take};
        drop_cnt_d = drop_cnt_q;
        occ_d      = occ_q + {1'b0, enq} - {1'b0, pop};

        if (redirect_take) begin
            fpc_d = redirect_pc_i;
        end else if (req_fire) begin
            // Natural wrap at 2^AWIDTH.
            fpc_d = fpc_q + AWIDTH'(4);
        end

        if (redirect_take) begin
            // No request fires in a redirect cycle, so what remains in
            // flight after this cycle's retirement is all stale.
            drop_cnt_d = out_cnt_q - {1'b0, rsp_take};
            occ_d      = 2'd0;
        end else if (rsp_take && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    // Control FSM; halted_o is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (halt_i) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_BOOT;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= BASEADDR;
            out_cnt_q   <= 2'd0;
            drop_cnt_q  <= 2'd0;
            occ_q       <= 2'd0;
            ifl_wr_q    <= 1'b0;
            ifl_rd_q    <= 1'b0;
            q_wr_q      <= 1'b0;
            q_rd_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ifl_pc_q[i] <= '0;
                q_pc_q[i]   <= '0;
                q_insn_q[i] <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            occ_q      <= occ_d;

            if (req_fire) begin
                ifl_pc_q[ifl_wr_q] <= fpc_q;
                ifl_wr_q           <= ~ifl_wr_q;
            end
            if (rsp_take) begin
                ifl_rd_q <= ~ifl_rd_q;
            end

            if (redirect_take) begin
                q_wr_q <= 1'b0;
                q_rd_q <= 1'b0;
            end else begin
                if (enq) begin
                    q_pc_q[q_wr_q]   <= rsp_pc;
                    q_insn_q[q_wr_q] <= imem_rsp_data_i;
                    q_wr_q           <= ~q_wr_q;
                end
                if (pop) begin
                    q_rd_q <= ~q_rd_q;
                end
            end
        end
    end

endmodule
